// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, instruction field widths and PC constants
// for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, FLUSH, HALT} fetch_state_t;
    localparam int OPCODE_W = 5;
    localparam int REG_W = 5;
    localparam int IMM_W = 12;
    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'h1F;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: count-based synchronous instruction buffer with flush; the head
// entry is read straight from registers so the output is registered.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && (count != 4'd0);
    // a full buffer still accepts a push when the same cycle pops
    assign do_push = push && ((count != 4'(DEPTH)) || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            count <= count + 4'(do_push) - 4'(do_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: credit-limited fetch with redirect flush and buffered
// decoder interface; define IFETCH_HALT_EN to stop fetching on a popped halt opcode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        halted
);
    fetch_state_t state;
    logic [31:0] pc, rsp_pc;
    logic [3:0] inflight, discard_cnt, fifo_count, rsp_left;
    logic started, req_hs, pop, push, halt_pop, flush;
    logic [63:0] fifo_dout;
    assign inst_valid = fifo_count != 4'd0;
    assign pop = inst_valid && inst_ready;
`ifdef IFETCH_HALT_EN
    assign halt_pop = pop && (instruction[OPCODE_W-1:0] == HALT_OPCODE);
    assign halted = state == HALT;
`else
    assign halt_pop = 1'b0;
    assign halted = 1'b0;
`endif
    assign imem_req_valid = started && (state == FETCH) && !redirect_valid
                            && ((5'(fifo_count) + 5'(inflight)) < 5'(FIFO_DEPTH));
    assign imem_req_addr = pc;
    assign req_hs = imem_req_valid && imem_req_ready;
    assign push = imem_rsp_valid && (state == FETCH) && !redirect_valid && !halt_pop;
    assign flush = redirect_valid || halt_pop;
    // in FETCH the outstanding requests are contiguous and end just below pc
    assign rsp_pc = pc - 32'(inflight) * PC_STEP;
    assign rsp_left = inflight - 4'(imem_rsp_valid);
    assign {inst_pc, instruction} = fifo_dout;
    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(64)
    ) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .push(push),
        .din({rsp_pc, imem_rsp_data}),
        .pop(pop),
        .dout(fifo_dout),
        .count(fifo_count)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            inflight <= '0;
            discard_cnt <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            inflight <= inflight + 4'(req_hs) - 4'(imem_rsp_valid);
            if (redirect_valid) begin
                pc <= redirect_pc;
                discard_cnt <= rsp_left;
                state <= (rsp_left != 4'd0) ? FLUSH : FETCH;
            end else begin
                if (req_hs) pc <= pc + PC_STEP;
                if (state == FETCH && halt_pop) state <= HALT;
                if (state == FLUSH && imem_rsp_valid) begin
                    discard_cnt <= discard_cnt - 4'd1;
                    if (discard_cnt == 4'd1) state <= FETCH;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios against an in-order memory model
// with programmable latency; builds with or without IFETCH_HALT_EN.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        halted;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    longint cyc = 0;
    int n_hs = 0, n_rsp = 0, n_pop = 0;
    typedef struct {
        logic [31:0] addr;
        longint due;
    } pend_t;
    pend_t pend[$];
    logic [31:0] req_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk),
        .reset_n(reset_n),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .instruction(instruction),
        .inst_pc(inst_pc),
        .halted(halted)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h0000_8004) ? 32'h0000_001F : a + 32'h1000_0000;
    endfunction

    // memory model: in-order responses lat cycles after the request handshake
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            pend.delete();
            imem_rsp_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + lat});
                req_log.push_back(imem_req_addr);
                n_hs <= n_hs + 1;
            end
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data <= mdata(pend[0].addr);
                void'(pend.pop_front());
                n_rsp <= n_rsp + 1;
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            if (inst_valid && inst_ready) begin
                got_pc.push_back(inst_pc);
                got_ins.push_back(instruction);
                n_pop <= n_pop + 1;
            end
        end
    end

    task automatic wait_pops(input int n, output bit ok);
        for (int i = 0; i < 100 && got_pc.size() < n; i++) @(negedge clk);
        ok = got_pc.size() >= n;
    endtask

    task automatic pulse_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc = a;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        reset_n = 1'b1;
        #1;
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL first_cycle_req: got %b want 0", imem_req_valid); end
        @(negedge clk);
        tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin
            fails++; $display("FAIL first_req: got valid %b addr %h want 1 00002000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential;
        bit ok;
        logic [31:0] exp;
        wait_pops(3, ok);
        tests++; if (!ok) begin fails++; $display("FAIL seq_timeout: got %0d pops want 3", got_pc.size()); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                exp = 32'h2000 + 32'(4 * i);
                tests++; if (req_log[i] !== exp) begin fails++; $display("FAIL seq_addr%0d: got %h want %h", i, req_log[i], exp); end
                tests++; if (got_pc[i] !== exp) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", i, got_pc[i], exp); end
                tests++; if (got_ins[i] !== mdata(exp)) begin fails++; $display("FAIL seq_ins%0d: got %h want %h", i, got_ins[i], mdata(exp)); end
            end
        end
    endtask

    task automatic test_backpressure;
        int max_occ, base;
        bit ok, bad;
        logic [31:0] cap_pc, cap_ins;
        max_occ = 0;
        cap_pc = '0;
        cap_ins = '0;
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (n_hs - n_pop > max_occ) max_occ = n_hs - n_pop;
            if (i == 2) begin cap_pc = inst_pc; cap_ins = instruction; end
        end
        tests++; if (max_occ != 2) begin fails++; $display("FAIL bp_occupancy: got %0d want 2", max_occ); end
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_credit: got req_valid %b want 0", imem_req_valid); end
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== cap_pc || instruction !== cap_ins) begin
            fails++; $display("FAIL bp_hold: got %b %h %h want 1 %h %h", inst_valid, inst_pc, instruction, cap_pc, cap_ins);
        end
        base = got_pc.size();
        inst_ready = 1'b1;
        wait_pops(base + 4, ok);
        bad = !ok;
        for (int i = 1; i < got_pc.size(); i++)
            if (got_pc[i] !== got_pc[i-1] + 32'd4 || got_ins[i] !== mdata(got_pc[i])) bad = 1'b1;
        tests++; if (bad) begin fails++; $display("FAIL bp_order: got %0d pops, sequence broken, want contiguous from 00002000", got_pc.size()); end
    endtask

    task automatic test_redirect;
        int base_req, base_pop;
        bit ok;
        imem_req_ready = 1'b0;
        repeat (6) @(negedge clk);
        lat = 3;
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (n_hs - n_rsp != 2 || imem_req_valid !== 1'b0) begin
            fails++; $display("FAIL redir_inflight: got %0d outstanding req_valid %b want 2 0", n_hs - n_rsp, imem_req_valid);
        end
        pulse_redirect(32'h4000);
        tests++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            fails++; $display("FAIL redir_flush_idle: got req %b inst %b want 0 0", imem_req_valid, inst_valid);
        end
        base_req = req_log.size();
        base_pop = got_pc.size();
        wait_pops(base_pop + 1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL redir_timeout: got %0d pops want %0d", got_pc.size(), base_pop + 1); end
        if (ok) begin
            tests++; if (got_pc[base_pop] !== 32'h4000) begin fails++; $display("FAIL redir_pc: got %h want 00004000", got_pc[base_pop]); end
            tests++; if (got_ins[base_pop] !== mdata(32'h4000)) begin fails++; $display("FAIL redir_ins: got %h want %h", got_ins[base_pop], mdata(32'h4000)); end
            tests++; if (req_log[base_req] !== 32'h4000) begin fails++; $display("FAIL redir_addr: got %h want 00004000", req_log[base_req]); end
        end
    endtask

    task automatic test_collision;
        int base_req, base_pop;
        bit ok, found;
        imem_req_ready = 1'b0;
        repeat (8) @(negedge clk);
        lat = 1;
        imem_req_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && imem_rsp_valid) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL coll_setup: got no pop+response cycle want one"); end
        if (found) begin
            pulse_redirect(32'h6000);
            tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL coll_spurious: got inst_valid %b want 0", inst_valid); end
            inst_ready = 1'b0;
            base_req = req_log.size();
            repeat (8) @(negedge clk);
            tests++; if (req_log.size() - base_req != 2) begin fails++; $display("FAIL coll_credit: got %0d requests want 2", req_log.size() - base_req); end
            if (req_log.size() > base_req) begin
                tests++; if (req_log[base_req] !== 32'h6000) begin fails++; $display("FAIL coll_addr: got %h want 00006000", req_log[base_req]); end
            end
            inst_ready = 1'b1;
            base_pop = got_pc.size();
            wait_pops(base_pop + 2, ok);
            tests++;
            if (!ok || got_pc[base_pop] !== 32'h6000 || got_pc[base_pop+1] !== 32'h6004) begin
                fails++; $display("FAIL coll_pcs: got %0d pops (ok=%0d) want 00006000 00006004", got_pc.size() - base_pop, ok);
            end
        end
    endtask

    task automatic test_wrap;
        int base_req, base_pop;
        bit ok;
        logic [31:0] exp;
        inst_ready = 1'b1;
        pulse_redirect(32'hFFFF_FFF8);
        base_req = req_log.size();
        base_pop = got_pc.size();
        wait_pops(base_pop + 3, ok);
        tests++; if (!ok) begin fails++; $display("FAIL wrap_timeout: got %0d pops want 3", got_pc.size() - base_pop); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                exp = 32'hFFFF_FFF8 + 32'(4 * i);
                tests++; if (req_log[base_req+i] !== exp) begin fails++; $display("FAIL wrap_addr%0d: got %h want %h", i, req_log[base_req+i], exp); end
                tests++; if (got_pc[base_pop+i] !== exp) begin fails++; $display("FAIL wrap_pc%0d: got %h want %h", i, got_pc[base_pop+i], exp); end
            end
        end
    endtask

    task automatic test_mid_reset;
        int base_req, base_pop;
        bit ok;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst_pc !== 32'h0) begin
            fails++; $display("FAIL mid_reset_outputs: got %b %b %h want 0 0 00000000", inst_valid, imem_req_valid, inst_pc);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base_req = req_log.size();
        base_pop = got_pc.size();
        wait_pops(base_pop + 2, ok);
        tests++;
        if (!ok || req_log[base_req] !== 32'h2000 || got_pc[base_pop] !== 32'h2000 || got_pc[base_pop+1] !== 32'h2004) begin
            fails++; $display("FAIL mid_reset_restart: got %0d pops (ok=%0d) want 00002000 00002004", got_pc.size() - base_pop, ok);
        end
    endtask

    task automatic test_opcode;
        int base_pop;
        bit ok, found, bad;
        pulse_redirect(32'h8000);
        base_pop = got_pc.size();
        found = 1'b0;
        bad = 1'b0;
`ifdef IFETCH_HALT_EN
        for (int i = 0; i < 40 && !found; i++) begin
            if (inst_valid && inst_pc == 32'h8004) found = 1'b1;
            else @(negedge clk);
        end
        tests++; if (!found) begin fails++; $display("FAIL halt_setup: got no 00008004 presented want one"); end
        if (found) begin
            @(negedge clk);
            tests++;
            if (halted !== 1'b1 || imem_req_valid !== 1'b0) begin
                fails++; $display("FAIL halt_entry: got halted %b req %b want 1 0", halted, imem_req_valid);
            end
            repeat (10) begin
                @(negedge clk);
                if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b1) bad = 1'b1;
            end
            tests++; if (bad) begin fails++; $display("FAIL halt_hold: got activity while halted want none"); end
            pulse_redirect(32'h9000);
            tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_exit: got %b want 0", halted); end
            base_pop = got_pc.size();
            wait_pops(base_pop + 1, ok);
            tests++;
            if (!ok || got_pc[base_pop] !== 32'h9000) begin
                fails++; $display("FAIL halt_resume: got %0d pops (ok=%0d) want 00009000", got_pc.size() - base_pop, ok);
            end
        end
`else
        for (int i = 0; i < 60 && got_pc.size() < base_pop + 3; i++) begin
            if (halted !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        ok = got_pc.size() >= base_pop + 3;
        tests++; if (!ok) begin fails++; $display("FAIL op_timeout: got %0d pops want 3", got_pc.size() - base_pop); end
        tests++; if (bad || halted !== 1'b0) begin fails++; $display("FAIL op_halted: got halted asserted want 0"); end
        if (ok) begin
            tests++;
            if (got_pc[base_pop] !== 32'h8000 || got_pc[base_pop+1] !== 32'h8004 || got_pc[base_pop+2] !== 32'h8008) begin
                fails++; $display("FAIL op_pcs: got %h %h %h want 00008000 00008004 00008008", got_pc[base_pop], got_pc[base_pop+1], got_pc[base_pop+2]);
            end
            tests++; if (got_ins[base_pop+1] !== 32'h0000_001F) begin fails++; $display("FAIL op_ins: got %h want 0000001f", got_ins[base_pop+1]); end
        end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        test_reset;
        test_sequential;
        test_backpressure;
        test_redirect;
        test_collision;
        test_wrap;
        test_mid_reset;
        test_opcode;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_2000: PC value loaded at reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries, legal range 2..8.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 redirect_valid  in  1  branch/jump redirect request, one-cycle pulse.
REQ-007 redirect_pc  in  32  redirect target, word-aligned.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_req_addr  out  32  fetch address.
REQ-011 imem_rsp_valid  in  1  in-order response valid; never back-pressured.
REQ-012 imem_rsp_data  in  32  fetched instruction word.
REQ-013 inst_valid  out  1  instruction available to the decoder.
REQ-014 inst_ready  in  1  decoder consumes instruction.
REQ-015 instruction  out  32  instruction word to the decoder (opcode in [4:0]).
REQ-016 inst_pc  out  32  address of the presented instruction.
REQ-017 halted  out  1  fetch stopped (halt configuration only; constant 0 otherwise).

Function
REQ-018 States SHALL be FETCH, FLUSH, HALT.
REQ-019 Request handshake completes when imem_req_valid && imem_req_ready; PC then advances by 4 next cycle; imem_req_addr = PC.
REQ-020 imem_req_valid SHALL be high only in FETCH, with redirect_valid low, and when fifo_count + inflight < FIFO_DEPTH (credit rule; responses can always be stored).
REQ-021 inflight SHALL increment on request handshake, decrement on imem_rsp_valid, both in one cycle leaving it unchanged.
REQ-022 In FETCH, each response SHALL be written to the FIFO with its PC; first response after reset or redirect reaches inst_valid one cycle later (registered output).
REQ-023 Output handshake completes on inst_valid && inst_ready; FIFO pops; data/pc stable while inst_valid && !inst_ready.
REQ-024 Simultaneous FIFO push and pop SHALL leave count unchanged, including when full.
REQ-025 On redirect_valid: FIFO cleared, PC <= redirect_pc, discard_cnt <= inflight minus any same-cycle response; next state FLUSH if discard_cnt nonzero, else FETCH.
REQ-026 In FLUSH, responses SHALL be dropped and decrement discard_cnt; at zero return to FETCH; inst_valid low.
REQ-027 redirect_valid in FLUSH or HALT SHALL restart the redirect sequence of REQ-025 (leaves HALT).
REQ-028 PC arithmetic SHALL be 32-bit unsigned and wrap from 32'hFFFF_FFFC to 0.

Reset
REQ-029 Reset SHALL force: state FETCH, PC = RESET_PC, FIFO empty, inflight = 0, discard_cnt = 0, imem_req_valid = 0 for the first cycle after deassertion, inst_valid = 0, instruction = 0, inst_pc = 0, halted = 0.
REQ-030 Reset asserted mid-operation SHALL abandon outstanding requests; late responses after deassertion are the memory's responsibility to suppress.

Configuration
REQ-031 Macro IFETCH_HALT_EN: when defined, popping an instruction with opcode HALT_OPCODE (5'h1F) SHALL enter HALT: no further requests, FIFO cleared, in-flight responses discarded, halted = 1.
REQ-032 Without IFETCH_HALT_EN, opcode 5'h1F is ordinary, HALT state is unreachable, halted tied 0.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the state enum, HALT_OPCODE, instruction field widths (opcode 5, reg 5, imm 12), and PC_STEP = 4.
REQ-034 The buffer SHALL be one sub-module, fetch_fifo (synchronous, count-based, flush input).

Verification
REQ-035 Reset release, imem_req_ready = 1, 1-cycle memory -> addresses 0x2000, 0x2004, 0x2008 in order; inst_pc matches.
REQ-036 inst_ready = 0 for 10 cycles -> at most FIFO_DEPTH outstanding+buffered; no response lost; order preserved on release.
REQ-037 Redirect to 0x4000 with 2 in flight -> both responses dropped, next instruction presented has inst_pc 0x4000.
REQ-038 Redirect coincident with a response and a pop -> response dropped, no spurious inst_valid, inflight returns to 0.
REQ-039 PC = 0xFFFF_FFFC fetch -> next request address 0x0000_0000.
REQ-040 IFETCH_HALT_EN, word 32'h0000_001F popped -> halted = 1 next cycle, imem_req_valid stays 0 until redirect.
